// File: rtl/gbf_wr_dispatch.sv
// gbf_wr_dispatch: header-decoding dispatcher steering pad words to the config channel or one of four GBF write ports
//   clk, Reset (sync, active-high); I_dat/I_val/I_rdy input word handshake, hold forces I_rdy low;
//   IFCFG/IFCFG_Val config output; GBF*_EnWr, GBFWEI_AddrWr, GBFACT_AddrWr, GBF_DatWr write ports;
//   pkt_done pulses with a packet's last write, pkt_err pulses after an illegal header.
module gbf_wr_dispatch #(
  parameter int PORT_DATAWIDTH   = 32,
  parameter int GBFWEI_ADDRWIDTH = 9,
  parameter int GBFACT_ADDRWIDTH = 9
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic [PORT_DATAWIDTH-1:0]   I_dat,
  input  logic                        I_val,
  output logic                        I_rdy,
  input  logic                        hold,
  output logic [PORT_DATAWIDTH-1:0]   IFCFG,
  output logic                        IFCFG_Val,
  output logic                        GBFFLGWEI_EnWr,
  output logic                        GBFWEI_EnWr,
  output logic                        GBFFLGACT_EnWr,
  output logic                        GBFACT_EnWr,
  output logic [GBFWEI_ADDRWIDTH-1:0] GBFWEI_AddrWr,
  output logic [GBFACT_ADDRWIDTH-1:0] GBFACT_AddrWr,
  output logic [PORT_DATAWIDTH-1:0]   GBF_DatWr,
  output logic                        pkt_done,
  output logic                        pkt_err
);
  localparam logic [1:0] IDLE = 2'd0, PAYLOAD = 2'd1, DROP = 2'd2;
  logic [1:0] state;
  logic [15:0] cnt;
  logic [2:0] dest;
  logic [GBFWEI_ADDRWIDTH-1:0] ptr_fw, ptr_w;
  logic [GBFACT_ADDRWIDTH-1:0] ptr_fa, ptr_a;
  logic xfer, hdr, wr, last, legal, clr;
  logic [3:0] hdest;
  assign I_rdy = !hold && !Reset;
  assign xfer  = I_val && I_rdy;
  assign hdest = I_dat[3:0];
  assign clr   = I_dat[20];
  assign legal = hdest <= 4'd4;
  assign hdr   = xfer && state == IDLE;
  assign wr    = xfer && state == PAYLOAD;
  assign last  = cnt == 16'd0;
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      dest <= '0;
      ptr_fw <= '0;
      ptr_w <= '0;
      ptr_fa <= '0;
      ptr_a <= '0;
      IFCFG <= '0;
      IFCFG_Val <= 1'b0;
      GBFFLGWEI_EnWr <= 1'b0;
      GBFWEI_EnWr <= 1'b0;
      GBFFLGACT_EnWr <= 1'b0;
      GBFACT_EnWr <= 1'b0;
      GBFWEI_AddrWr <= '0;
      GBFACT_AddrWr <= '0;
      GBF_DatWr <= '0;
      pkt_done <= 1'b0;
      pkt_err <= 1'b0;
    end else begin
      IFCFG_Val <= wr && dest == 3'd0;
      GBFFLGWEI_EnWr <= wr && dest == 3'd1;
      GBFWEI_EnWr <= wr && dest == 3'd2;
      GBFFLGACT_EnWr <= wr && dest == 3'd3;
      GBFACT_EnWr <= wr && dest == 3'd4;
      pkt_done <= wr && last;
      pkt_err <= hdr && !legal;
      if (wr) begin
        IFCFG <= I_dat;
        GBF_DatWr <= I_dat;
      end
      if (wr && (dest == 3'd1 || dest == 3'd2)) GBFWEI_AddrWr <= dest == 3'd1 ? ptr_fw : ptr_w;
      if (wr && (dest == 3'd3 || dest == 3'd4)) GBFACT_AddrWr <= dest == 3'd3 ? ptr_fa : ptr_a;
      if (wr && dest == 3'd1) ptr_fw <= ptr_fw + 1'b1;
      if (wr && dest == 3'd2) ptr_w <= ptr_w + 1'b1;
      if (wr && dest == 3'd3) ptr_fa <= ptr_fa + 1'b1;
      if (wr && dest == 3'd4) ptr_a <= ptr_a + 1'b1;
      // clr is applied at the header edge so the first payload word already sees address 0
      if (hdr && clr && hdest == 4'd1) ptr_fw <= '0;
      if (hdr && clr && hdest == 4'd2) ptr_w <= '0;
      if (hdr && clr && hdest == 4'd3) ptr_fa <= '0;
      if (hdr && clr && hdest == 4'd4) ptr_a <= '0;
      if (hdr) begin
        state <= legal ? PAYLOAD : DROP;
        cnt <= I_dat[19:4];
        dest <= hdest[2:0];
      end else if (xfer && state != IDLE) begin
        if (last) state <= IDLE;
        else cnt <= cnt - 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_gbf_wr_dispatch.sv
// tb_gbf_wr_dispatch: directed self-checking bench for gbf_wr_dispatch
module tb_gbf_wr_dispatch;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic [31:0] I_dat = '0;
  logic I_val = 1'b0;
  logic I_rdy;
  logic hold = 1'b0;
  logic [31:0] IFCFG;
  logic IFCFG_Val;
  logic GBFFLGWEI_EnWr, GBFWEI_EnWr, GBFFLGACT_EnWr, GBFACT_EnWr;
  logic [8:0] GBFWEI_AddrWr, GBFACT_AddrWr;
  logic [31:0] GBF_DatWr;
  logic pkt_done, pkt_err;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int multi = 0;
  int errs = 0;
  int stray_done = 0;
  typedef struct {int kind; int addr; logic [31:0] data; logic done; int cyc;} rec_t;
  rec_t q[$];
  rec_t r;
  logic [4:0] en;

  gbf_wr_dispatch dut (
    .clk(clk), .Reset(Reset), .I_dat(I_dat), .I_val(I_val), .I_rdy(I_rdy), .hold(hold),
    .IFCFG(IFCFG), .IFCFG_Val(IFCFG_Val),
    .GBFFLGWEI_EnWr(GBFFLGWEI_EnWr), .GBFWEI_EnWr(GBFWEI_EnWr),
    .GBFFLGACT_EnWr(GBFFLGACT_EnWr), .GBFACT_EnWr(GBFACT_EnWr),
    .GBFWEI_AddrWr(GBFWEI_AddrWr), .GBFACT_AddrWr(GBFACT_AddrWr),
    .GBF_DatWr(GBF_DatWr), .pkt_done(pkt_done), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    en = {GBFACT_EnWr, GBFFLGACT_EnWr, GBFWEI_EnWr, GBFFLGWEI_EnWr, IFCFG_Val};
    if ($countones(en) > 1) multi++;
    if (pkt_err) errs++;
    if (pkt_done && en == 5'd0) stray_done++;
    if (en != 5'd0) begin
      r.kind = IFCFG_Val ? 0 : GBFFLGWEI_EnWr ? 1 : GBFWEI_EnWr ? 2 : GBFFLGACT_EnWr ? 3 : 4;
      r.addr = (r.kind == 1 || r.kind == 2) ? int'(GBFWEI_AddrWr) : int'(GBFACT_AddrWr);
      r.data = r.kind == 0 ? IFCFG : GBF_DatWr;
      r.done = pkt_done;
      r.cyc = cyc;
      q.push_back(r);
    end
  end

  function automatic logic [31:0] hdr(input int d, input int len_m1, input bit clr);
    hdr = {11'b0, clr, len_m1[15:0], d[3:0]};
  endfunction

  task automatic push(input logic [31:0] w);
    int n;
    I_dat = w;
    I_val = 1'b1;
    n = 0;
    forever begin
      @(posedge clk);
      if (I_rdy) break;
      n++;
      if (n > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL push_timeout: I_rdy stayed %b, required 1", I_rdy);
        break;
      end
    end
    #1 I_val = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    I_val = 1'b0;
    hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    q.delete();
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (I_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b want 0", I_rdy); end
    vectors++;
    if ({IFCFG_Val, GBFFLGWEI_EnWr, GBFWEI_EnWr, GBFFLGACT_EnWr, GBFACT_EnWr, pkt_done, pkt_err} !== 7'b0) begin
      miscompares++; $display("FAIL reset_strobes: got %b want 0", {IFCFG_Val, GBFFLGWEI_EnWr, GBFWEI_EnWr, GBFFLGACT_EnWr, GBFACT_EnWr, pkt_done, pkt_err});
    end
    vectors++;
    if ({GBFWEI_AddrWr, GBFACT_AddrWr, GBF_DatWr, IFCFG} !== 82'b0) begin
      miscompares++; $display("FAIL reset_data: addr %0d/%0d dat %h cfg %h want 0", GBFWEI_AddrWr, GBFACT_AddrWr, GBF_DatWr, IFCFG);
    end
    @(posedge clk);
    #1 Reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (I_rdy !== 1'b1) begin miscompares++; $display("FAIL release_rdy: got %b want 1", I_rdy); end
    q.delete();
  endtask

  task automatic test_single();
    do_reset();
    push(hdr(2, 3, 1));
    for (int i = 0; i < 4; i++) push(32'hA000_0000 + i);
    drain();
    vectors++;
    if (q.size() !== 4) begin miscompares++; $display("FAIL single_count: got %0d want 4", q.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q[i].kind !== 2 || q[i].addr !== i || q[i].data !== 32'hA000_0000 + i || q[i].done !== (i == 3) || q[i].cyc !== q[0].cyc + i) begin
        miscompares++;
        $display("FAIL single_w%0d: kind %0d addr %0d data %h done %b cyc+%0d want 2/%0d/%h/%b/+%0d", i, q[i].kind, q[i].addr, q[i].data, q[i].done, q[i].cyc - q[0].cyc, i, 32'hA000_0000 + i, i == 3, i);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      push(hdr(4, 299, 0));
      for (int i = 0; i < 300; i++) push(32'h4000_0000 + p * 1000 + i);
    end
    drain();
    vectors++;
    if (q.size() !== 600) begin miscompares++; $display("FAIL wrap_count: got %0d want 600", q.size()); end
    else for (int i = 0; i < 300; i++) begin
      vectors++;
      if (q[300 + i].kind !== 4 || q[300 + i].addr !== (300 + i) % 512 || q[300 + i].done !== (i == 299) || q[300 + i].data !== 32'h4000_0000 + 1000 + i) begin
        miscompares++;
        $display("FAIL wrap_w%0d: kind %0d addr %0d done %b data %h want 4/%0d/%b/%h", i, q[300 + i].kind, q[300 + i].addr, q[300 + i].done, q[300 + i].data, (300 + i) % 512, i == 299, 32'h4000_0000 + 1000 + i);
      end
    end
  endtask

  task automatic test_cfg_interleave();
    int m0;
    do_reset();
    m0 = multi;
    push(hdr(0, 1, 0));
    push(32'hC0C0_0001);
    push(32'hC0C0_0002);
    push(hdr(1, 0, 0));
    push(32'hF1F1_0003);
    drain();
    vectors++;
    if (q.size() !== 3) begin miscompares++; $display("FAIL cfg_count: got %0d want 3", q.size()); end
    else begin
      vectors++;
      if (q[0].kind !== 0 || q[0].data !== 32'hC0C0_0001 || q[0].done !== 1'b0) begin miscompares++; $display("FAIL cfg_w0: kind %0d data %h done %b want 0/C0C00001/0", q[0].kind, q[0].data, q[0].done); end
      vectors++;
      if (q[1].kind !== 0 || q[1].data !== 32'hC0C0_0002 || q[1].done !== 1'b1 || q[1].cyc !== q[0].cyc + 1) begin miscompares++; $display("FAIL cfg_w1: kind %0d data %h done %b want 0/C0C00002/1", q[1].kind, q[1].data, q[1].done); end
      vectors++;
      if (q[2].kind !== 1 || q[2].addr !== 0 || q[2].data !== 32'hF1F1_0003 || q[2].done !== 1'b1) begin miscompares++; $display("FAIL flgwei_w: kind %0d addr %0d data %h done %b want 1/0/F1F10003/1", q[2].kind, q[2].addr, q[2].data, q[2].done); end
    end
    vectors++;
    if (multi !== m0) begin miscompares++; $display("FAIL onehot: %0d multi-enable cycles, want 0", multi - m0); end
  endtask

  task automatic test_illegal();
    int e0;
    do_reset();
    e0 = errs;
    push(hdr(7, 1, 0));
    push(32'hDEAD_0001);
    push(32'hDEAD_0002);
    drain();
    vectors++;
    if (errs - e0 !== 1) begin miscompares++; $display("FAIL err_pulses: got %0d want 1", errs - e0); end
    vectors++;
    if (q.size() !== 0) begin miscompares++; $display("FAIL drop_writes: got %0d want 0", q.size()); end
    push(hdr(2, 0, 0));
    push(32'h5555_AAAA);
    drain();
    vectors++;
    if (q.size() !== 1) begin miscompares++; $display("FAIL after_drop_count: got %0d want 1", q.size()); end
    else begin
      vectors++;
      if (q[0].kind !== 2 || q[0].addr !== 0 || q[0].data !== 32'h5555_AAAA || q[0].done !== 1'b1) begin miscompares++; $display("FAIL after_drop_w: kind %0d addr %0d data %h done %b want 2/0/5555AAAA/1", q[0].kind, q[0].addr, q[0].data, q[0].done); end
    end
    vectors++;
    if (errs - e0 !== 1) begin miscompares++; $display("FAIL err_total: got %0d want 1", errs - e0); end
  endtask

  task automatic test_stall();
    do_reset();
    push(hdr(3, 3, 0));
    push(32'h3300_0000);
    push(32'h3300_0001);
    hold = 1'b1;
    I_dat = 32'h3300_0002;
    I_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (I_rdy !== 1'b0) begin miscompares++; $display("FAIL stall_rdy%0d: got %b want 0", i, I_rdy); end
      @(posedge clk);
    end
    #1 hold = 1'b0;
    push(32'h3300_0002);
    push(32'h3300_0003);
    drain();
    vectors++;
    if (q.size() !== 4) begin miscompares++; $display("FAIL stall_count: got %0d want 4", q.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q[i].kind !== 3 || q[i].addr !== i || q[i].data !== 32'h3300_0000 + i || q[i].done !== (i == 3)) begin
        miscompares++;
        $display("FAIL stall_w%0d: kind %0d addr %0d data %h done %b want 3/%0d/%h/%b", i, q[i].kind, q[i].addr, q[i].data, q[i].done, i, 32'h3300_0000 + i, i == 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    do_reset();
    s0 = stray_done;
    push(hdr(2, 4, 0));
    push(32'h7700_0000);
    push(32'h7700_0001);
    Reset = 1'b1;
    I_dat = 32'h7700_0002;
    I_val = 1'b1;
    @(posedge clk);
    #1 Reset = 1'b0;
    I_val = 1'b0;
    drain();
    vectors++;
    if (q.size() !== 2) begin miscompares++; $display("FAIL abort_count: got %0d want 2", q.size()); end
    else for (int i = 0; i < 2; i++) begin
      vectors++;
      if (q[i].addr !== i || q[i].done !== 1'b0) begin miscompares++; $display("FAIL abort_w%0d: addr %0d done %b want %0d/0", i, q[i].addr, q[i].done, i); end
    end
    vectors++;
    if (stray_done !== s0) begin miscompares++; $display("FAIL abort_done: %0d stray pkt_done, want 0", stray_done - s0); end
    q.delete();
    push(hdr(2, 0, 0));
    push(32'h7700_0009);
    drain();
    vectors++;
    if (q.size() !== 1) begin miscompares++; $display("FAIL post_abort_count: got %0d want 1", q.size()); end
    else begin
      vectors++;
      if (q[0].kind !== 2 || q[0].addr !== 0 || q[0].data !== 32'h7700_0009 || q[0].done !== 1'b1) begin miscompares++; $display("FAIL post_abort_w: kind %0d addr %0d data %h done %b want 2/0/77000009/1", q[0].kind, q[0].addr, q[0].data, q[0].done); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_cfg_interleave();
    test_illegal();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
